// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: 1-cycle loads and SW, 2-cycle registered RMW for SB/SH.
// Backpressure: stall is raised during the read half of a sub-word store.
module mem_access_unit #(
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  input  logic [31:0]       mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  output logic              mem_we,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              misaligned,
  output logic              illegal,
  output logic [CNT_W-1:0]  load_cnt,
  output logic [CNT_W-1:0]  store_cnt
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_WRITE = 1'b1;

  logic [0:0]        state;
  logic [31:0]       merge_q;
  logic [ADDR_W-1:0] addr_q;

  logic        in_write;
  logic        req_ok;
  logic        is_word;
  logic        word_store;
  logic [31:0] byte_sh;
  logic [31:0] half_sh;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;
  logic [31:0] merged;

  assign in_write = (state == S_WRITE);
  assign is_word  = (funct3 == 3'b010);

  always_comb begin
    misaligned = 1'b0;
    illegal    = 1'b0;
    if (req_valid) begin
      misaligned = ((funct3 == 3'b001 || funct3 == 3'b101) && addr[0]) ||
                   (is_word && (addr[1:0] != 2'b00));
      if (req_we)
        illegal = funct3[2] || (funct3 == 3'b011);
      else
        illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    end
  end

  assign req_ok     = !rst && !in_write && req_valid && !misaligned && !illegal;
  assign word_store = req_ok && req_we && is_word;
  assign stall      = req_ok && req_we && !is_word;
  assign load_valid = req_ok && !req_we;

  assign mem_addr = in_write ? addr_q : addr;
  assign mem_we   = (in_write && !rst) || word_store;
  assign mem_wd   = in_write ? merge_q : (word_store ? store_data : 32'h0);

  // Little-endian lane extraction; half offsets come from addr[1] only.
  always_comb begin
    byte_sh   = mem_rd >> {addr[1:0], 3'b000};
    half_sh   = mem_rd >> {addr[1], 4'b0000};
    load_data = 32'h0;
    if (load_valid) begin
      case (funct3[1:0])
        2'b00:   load_data = funct3[2] ? {24'h0, byte_sh[7:0]}
                                       : {{24{byte_sh[7]}}, byte_sh[7:0]};
        2'b01:   load_data = funct3[2] ? {16'h0, half_sh[15:0]}
                                       : {{16{half_sh[15]}}, half_sh[15:0]};
        default: load_data = mem_rd;
      endcase
    end
  end

  always_comb begin
    if (funct3[1:0] == 2'b00) begin
      lane_mask = 32'h0000_00FF << {addr[1:0], 3'b000};
      lane_data = {4{store_data[7:0]}};
    end else begin
      lane_mask = 32'h0000_FFFF << {addr[1], 4'b0000};
      lane_data = {2{store_data[15:0]}};
    end
    merged = (mem_rd & ~lane_mask) | (lane_data & lane_mask);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      merge_q <= 32'h0;
      addr_q  <= '0;
    end else if (in_write) begin
      state <= S_IDLE;
    end else if (stall) begin
      state   <= S_WRITE;
      merge_q <= merged;
      addr_q  <= addr;
    end
  end

  // Every commit to memory is a completed store, so mem_we drives store_cnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_cnt  <= '0;
      store_cnt <= '0;
    end else begin
      if (load_valid && (load_cnt != '1))
        load_cnt <= load_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      if (mem_we && (store_cnt != '1))
        store_cnt <= store_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
